// File: rtl/serial_alu_n.sv
// Bit-serial ALU: one logic/full-add slice reused over WIDTH cycles, LSB first.
// Optional overflow output: define SERIAL_ALU_OVERFLOW_EN to add port ovf.
module serial_alu_n #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             a_inv,
   input  logic             b_inv,
   input  logic             c_in,
   input  logic [2:0]       op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             zero
`ifdef SERIAL_ALU_OVERFLOW_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_NOR = 3'b011;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             a_inv_q, a_inv_d, b_inv_q, b_inv_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             c_out_q, c_out_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;

   logic             ai, bi, bit_out, carry_nxt, is_arith;
   logic [WIDTH-1:0] sr_shifted;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         a_inv_q  <= 1'b0;
         b_inv_q  <= 1'b0;
         op_q     <= '0;
         sr_q     <= '0;
         result_q <= '0;
         c_out_q  <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         b_q      <= b_d;
         a_inv_q  <= a_inv_d;
         b_inv_q  <= b_inv_d;
         op_q     <= op_d;
         sr_q     <= sr_d;
         result_q <= result_d;
         c_out_q  <= c_out_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
      end
   end

   // The single slice: operands are shifted right so bit 0 is always the live bit.
   always_comb begin
      is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
      ai        = a_q[0] ^ a_inv_q;
      bi        = b_q[0] ^ b_inv_q ^ (op_q == OP_SUB);
      carry_nxt = (ai & bi) | (ai & carry_q) | (bi & carry_q);
      case (op_q)
         OP_AND:         bit_out = ai & bi;
         OP_OR:          bit_out = ai | bi;
         OP_XOR:         bit_out = ai ^ bi;
         OP_NOR:         bit_out = ~(ai | bi);
         OP_ADD, OP_SUB: bit_out = ai ^ bi ^ carry_q;
         default:        bit_out = 1'b0;
      endcase
      sr_shifted = {bit_out, sr_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      a_inv_d  = a_inv_q;
      b_inv_d  = b_inv_q;
      op_d     = op_q;
      sr_d     = sr_q;
      result_d = result_q;
      c_out_d  = c_out_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      case (state_q)
         RUN: begin
            sr_d  = sr_shifted;
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (is_arith) carry_d = carry_nxt;
            if (cnt_q == LAST) begin
               state_d  = DONE;
               result_d = sr_shifted;
               zero_d   = (sr_shifted == '0);
               c_out_d  = is_arith & carry_nxt;
               // Carry into the MSB is the carry register at the last bit.
               ovf_d    = is_arith & (carry_q ^ carry_nxt);
            end
         end
         default: begin
            if (start) begin
               state_d = RUN;
               cnt_d   = '0;
               a_d     = a;
               b_d     = b;
               a_inv_d = a_inv;
               b_inv_d = b_inv;
               op_d    = op;
               sr_d    = '0;
               carry_d = (op == OP_SUB) ? 1'b1 : ((op == OP_ADD) ? c_in : 1'b0);
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);
   assign result = result_q;
   assign c_out  = c_out_q;
   assign zero   = zero_q;
`ifdef SERIAL_ALU_OVERFLOW_EN
   assign ovf    = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q ^ ovf_d;
`endif

endmodule

// File: tb/tb_serial_alu_n.sv
// Randomized self-checking bench for serial_alu_n against an arithmetic reference model.
module tb_serial_alu_n;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         a_inv, b_inv, c_in;
   logic [2:0]   op;
   logic         busy, done;
   logic [W-1:0] result;
   logic         c_out, zero;
   logic         ovf;

   int n_vec  = 0;
   int n_miss = 0;

   // expected values of the pending op and of the currently held outputs
   logic [W-1:0] pend_r, held_r;
   logic         pend_c, pend_z, pend_v, held_c, held_z, held_v;

   serial_alu_n #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .a_inv(a_inv), .b_inv(b_inv), .c_in(c_in), .op(op),
      .busy(busy), .done(done), .result(result), .c_out(c_out), .zero(zero)
`ifdef SERIAL_ALU_OVERFLOW_EN
      , .ovf(ovf)
`endif
   );

`ifndef SERIAL_ALU_OVERFLOW_EN
   assign ovf = 1'b0;
`endif

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout n_vec=%0d", n_vec);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic iai, input logic ibi, input logic ici,
                                 input logic [2:0] iop, output logic [W-1:0] r,
                                 output logic co, output logic z, output logic ov);
      logic [W-1:0] aa, bb;
      logic [W:0]   s;
      aa = iai ? ~ia : ia;
      bb = ibi ? ~ib : ib;
      co = 1'b0;
      ov = 1'b0;
      s  = '0;
      case (iop)
         3'b000: r = aa & bb;
         3'b001: r = aa | bb;
         3'b010: r = aa ^ bb;
         3'b011: r = ~(aa | bb);
         3'b100, 3'b101: begin
            if (iop == 3'b101) begin
               bb = ~bb;
               s  = {1'b0, aa} + {1'b0, bb} + (W+1)'(1);
            end else begin
               s  = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, ici};
            end
            r  = s[W-1:0];
            co = s[W];
            ov = (aa[W-1] == bb[W-1]) && (r[W-1] != aa[W-1]);
         end
         default: r = '0;
      endcase
      z = (r == '0);
   endfunction

   task automatic check_held(input string tag);
      check({tag, "_result_held"}, 32'(result), 32'(held_r));
      check({tag, "_cout_held"}, 32'(c_out), 32'(held_c));
      check({tag, "_zero_held"}, 32'(zero), 32'(held_z));
   endtask

   task automatic idle_check();
      @(posedge clk); #1;
      check("idle_done", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check_held("idle");
   endtask

   // Called at #1 after a rising edge; returns in the done cycle.
   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic iai,
                        input logic ibi, input logic ici, input logic [2:0] iop,
                        input bit interfere);
      a = ia; b = ib; a_inv = iai; b_inv = ibi; c_in = ici; op = iop; start = 1'b1;
      model(ia, ib, iai, ibi, ici, iop, pend_r, pend_c, pend_z, pend_v);
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); op = 3'($urandom); c_in = 1'($urandom);
      a_inv = 1'($urandom); b_inv = 1'($urandom);
      for (int j = 1; j <= W; j++) begin
         check("busy", 32'(busy), 32'd1);
         check("done_early", 32'(done), 32'd0);
         check_held("run");
         if (interfere && (j == 3 || j == 5)) begin
            start = 1'b1;
            a = W'($urandom); b = W'($urandom); op = 3'($urandom);
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      check("done", 32'(done), 32'd1);
      check("busy_in_done", 32'(busy), 32'd0);
      check("result", 32'(result), 32'(pend_r));
      check("c_out", 32'(c_out), 32'(pend_c));
      check("zero", 32'(zero), 32'(pend_z));
`ifdef SERIAL_ALU_OVERFLOW_EN
      check("ovf", 32'(ovf), 32'(pend_v));
`endif
      held_r = pend_r; held_c = pend_c; held_z = pend_z; held_v = pend_v;
      $display("op=%b a=%02h b=%02h ai=%0d bi=%0d ci=%0d -> result=%02h c_out=%0d zero=%0d ovf=%0d",
               iop, ia, ib, iai, ibi, ici, result, c_out, zero, ovf);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      a_inv = 1'b0; b_inv = 1'b0; c_in = 1'b0; op = 3'b000;
      held_r = '0; held_c = 1'b0; held_z = 1'b0; held_v = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check_held("rst");
      check("rst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;

      issue(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0);
      idle_check();
      issue(8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 3'b101, 1'b1);
      issue(8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 3'b101, 1'b0);
      idle_check();
      issue(8'h0F, 8'hFF, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
      issue(8'hF0, 8'h0F, 1'b0, 1'b0, 1'b0, 3'b011, 1'b0);
      issue(8'hAA, 8'hFF, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0);
      issue(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 3'b110, 1'b0);
      issue(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0);
      idle_check();

      // reset in the middle of an ADD
      a = 8'h12; b = 8'h34; a_inv = 1'b0; b_inv = 1'b0; c_in = 1'b0; op = 3'b100; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      held_r = '0; held_c = 1'b0; held_z = 1'b0; held_v = 1'b0;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check_held("midrst");
      for (int j = 0; j < W + 3; j++) idle_check();
      issue(8'h3C, 8'h0F, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 1) == 0) idle_check();
         issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               3'($urandom), ($urandom_range(0, 3) == 0));
      end
      idle_check();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/serial_alu_n.md
Name: serial_alu_n

Overview:
- Parametrised, bit-serial successor to the team's 1-bit ALU slice.
- Reuses one slice (operand inversion, AND/OR/XOR/NOR, full add) over WIDTH cycles, LSB first, with a carry register between bits.
- Start/busy/done handshake and registered result and flags.
- Sits beside the datapath as an area-cheap multi-cycle ALU for control code that can tolerate WIDTH+1 cycles of latency.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- a_inv  input  1  invert A before the op
- b_inv  input  1  invert B before the op
- c_in  input  1  carry-in for ADD
- op  input  3  000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110/111 result zero
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when result/flags become valid
- result  output  WIDTH  registered result, held until next accepted start
- c_out  output  1  carry out of MSB (ADD/SUB), else 0
- zero  output  1  result == 0

Behaviour:
- Single clock. Reset is synchronous, active-low: rst_n sampled low at a clk rising edge resets the block.
- Reset state: IDLE, busy=0, done=0, result=0, c_out=0, zero=0 (ovf=0 if present), bit counter=0, carry reg=0. Reset wins over start and aborts any operation in flight; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE or DONE, start=1: latch a, b, a_inv, b_inv, op. Carry reg = c_in for ADD; carry reg = 1 for SUB (SUB is A' + ~B' + 1, with A'/B' after inversion). Counter=0. Go to RUN. busy=1 from the next cycle.
- RUN: one bit per cycle, bit index = counter.
  - Bit operands: ai = a[i]^a_inv, bi = b[i]^b_inv (for SUB, bi additionally inverted).
  - Logic ops write ai op bi.
  - ADD/SUB write ai^bi^carry, and carry <= majority(ai,bi,carry).
  - Bits shift into a result shift register.
  - When counter==WIDTH-1, go to DONE on the next edge.
- Entering DONE:
  - result/c_out/zero update together.
  - done=1 for exactly one cycle; busy=0.
  - c_out = final carry for ADD/SUB, else 0.
- DONE with no start returns to IDLE. Outputs hold until the next accepted start completes.
- Latency: start sampled at edge k; busy high in cycles k+1..k+WIDTH; done high in cycle k+WIDTH+1. Back-to-back: start during the done cycle is accepted, giving a throughput of one op per WIDTH+1 cycles.
- start while busy=1: ignored, no queuing.
- result, c_out and zero are not updated during RUN; the previous values stay visible until done.
- Inputs a/b/op may change after the start edge without effect.
- op 110/111: runs WIDTH cycles, result=0, c_out=0, zero=1.

Optional Feature:
- Macro: SERIAL_ALU_OVERFLOW_EN.
- Defined: extra output port ovf (1 bit), updated with done. ovf = carry into MSB XOR carry out of MSB for ADD/SUB, else 0. Reset value 0.
- Undefined: no ovf port and no overflow logic. All other behaviour is identical.

Test Plan:
- Reset, then ADD a=0x7F, b=0x01, c_in=0, WIDTH=8, start at edge k -> busy cycles k+1..k+8; done only in cycle k+9; result=0x80, c_out=0, zero=0, ovf=1 if enabled.
- SUB a=0x05, b=0x05 -> result=0x00, c_out=1, zero=1, ovf=0. Then SUB a=0x00, b=0x01 -> result=0xFF, c_out=0.
- Logic with inversion: AND a=0x0F, a_inv=1, b=0xFF -> 0xF0. NOR a=0xF0, b=0x0F -> 0x00, zero=1. XOR a=0xAA, b=0xFF -> 0x55. op=110 -> 0x00, c_out=0.
- Protocol: pulse start again at cycles k+3 and k+5 during busy with different operands -> ignored, first result delivered unchanged. Start in the done cycle -> accepted, next done exactly 9 cycles later.
- Reset mid-op: rst_n low at cycle k+4 of an ADD -> next cycle busy=0, result=0, no done pulse. New start after release completes normally.
- Carry chain: ADD a=0xFF, b=0x00, c_in=1 -> result=0x00, c_out=1, zero=1. Changing a/b immediately after the start edge has no effect on the result.
